// File: rtl/set_pattern_driver.sv
// set_pattern_driver: walks a pattern store, issues one SET request per
// entry over en/busy/valid and tallies candidates that miss the expected count.
module set_pattern_driver #(
   parameter int NUM_PAT   = 64,
   parameter int ADDR_W    = 6,
   parameter int ERR_LIMIT = 10,
   parameter int TIMEOUT   = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode_sel,
   output logic [ADDR_W-1:0] pat_addr,
   input  logic [23:0]       pat_central,
   input  logic [11:0]       pat_radius,
   input  logic [7:0]        pat_expected,
   output logic              set_en,
   output logic [23:0]       set_central,
   output logic [11:0]       set_radius,
   output logic [1:0]        set_mode,
   input  logic              set_busy,
   input  logic              set_valid,
   input  logic [7:0]        set_candidate,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_cnt,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] cur_idx
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAIT_IDLE,
      S_ISSUE,
      S_WAIT_VALID,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [23:0]       central_q, central_d;
   logic [11:0]       radius_q, radius_d;
   logic [7:0]        exp_q, exp_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0]        err_q, err_d;
   logic              tmo_err_q, tmo_err_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;
   logic              miss_q, miss_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;

   logic [7:0] err_inc;
   logic       lim_hit;

   assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   assign lim_hit = (ERR_LIMIT != 0) && (int'(err_inc) >= ERR_LIMIT);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      central_d = central_q;
      radius_d  = radius_q;
      exp_d     = exp_q;
      mode_d    = mode_q;
      err_d     = err_q;
      tmo_err_d = tmo_err_q;
      done_d    = done_q;
      abort_d   = abort_q;
      miss_d    = miss_q;
      tcnt_d    = tcnt_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_FETCH;
               idx_d     = '0;
               addr_d    = '0;
               mode_d    = mode_sel;
               err_d     = '0;
               tmo_err_d = 1'b0;
               done_d    = 1'b0;
               abort_d   = 1'b0;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            central_d = pat_central;
            radius_d  = pat_radius;
            exp_d     = pat_expected;
            miss_d    = 1'b0;
            tcnt_d    = '0;
            state_d   = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (!set_busy) begin
               state_d = S_ISSUE;
            end else if (tcnt_q == TMAX) begin
               tmo_err_d = 1'b1;
               miss_d    = 1'b1;
               state_d   = S_CHECK;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_ISSUE: begin
            tcnt_d  = '0;
            state_d = S_WAIT_VALID;
         end
         S_WAIT_VALID: begin
            if (set_valid) begin
               miss_d  = (set_candidate != exp_q);
               state_d = S_CHECK;
            end else if (tcnt_q == TMAX) begin
               tmo_err_d = 1'b1;
               miss_d    = 1'b1;
               state_d   = S_CHECK;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (miss_q) err_d = err_inc;
            if (miss_q && lim_hit) begin
               abort_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (idx_q == LAST) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               addr_d  = idx_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         central_q <= '0;
         radius_q  <= '0;
         exp_q     <= '0;
         mode_q    <= '0;
         err_q     <= '0;
         tmo_err_q <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         miss_q    <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         central_q <= central_d;
         radius_q  <= radius_d;
         exp_q     <= exp_d;
         mode_q    <= mode_d;
         err_q     <= err_d;
         tmo_err_q <= tmo_err_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         miss_q    <= miss_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign set_en      = (state_q == S_ISSUE);
   assign pat_addr    = addr_q;
   assign set_central = central_q;
   assign set_radius  = radius_q;
   assign set_mode    = mode_q;
   assign done        = done_q;
   assign err_cnt     = err_q;
   assign timeout_err = tmo_err_q;
   assign cur_idx     = idx_q;
   assign pass        = done_q & (err_q == 8'd0) & ~tmo_err_q & ~abort_q;

endmodule
